// File: rtl/count_event_tracker.sv
// Watches a MOD-14 counter against its own controls, classifies wrap/load/error events,
// and queues event records in a small FIFO for a downstream consumer.
module count_event_tracker #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       rest,
  input  logic [3:0] cnt_in,
  input  logic       mode,
  input  logic       load,
  input  logic [3:0] data_in,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_data,
  output logic       fifo_full,
  output logic       ovf,
  output logic [7:0] wrap_cnt,
  output logic [7:0] err_cnt
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] T_ERR  = 2'b00;
  localparam logic [1:0] T_WUP  = 2'b01;
  localparam logic [1:0] T_WDN  = 2'b10;
  localparam logic [1:0] T_LOAD = 2'b11;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic logic [3:0] next_count(input logic [3:0] c, input logic m,
                                             input logic l, input logic [3:0] d);
    logic [3:0] r;
    if (l) begin
      r = d;
    end else if (m) begin
      r = (c == 4'd13) ? 4'd0 : c + 4'd1;
    end else begin
      r = (c == 4'd0) ? 4'd13 : c - 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  prev_cnt_q, prev_data_q;
  logic        prev_mode_q, prev_load_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  logic        evt_valid_q, evt_valid_d, fifo_full_q, fifo_full_d, ovf_q, ovf_d;
  logic [7:0]  evt_data_q, evt_data_d, wrap_q, wrap_d, err_q, err_d;

  logic [3:0]  exp_s;
  logic        evt_det_s;
  logic [1:0]  evt_type_s;
  logic [7:0]  evt_rec_s;
  logic        pop_s, push_s, drop_s;

  // Event classification and FSM next state
  always_comb begin
    exp_s      = next_count(prev_cnt_q, prev_mode_q, prev_load_q, prev_data_q);
    evt_det_s  = 1'b0;
    evt_type_s = T_ERR;
    state_d    = state_q;
    case (state_q)
      SYNC: begin
        if (cnt_in > 4'd13) begin
          evt_det_s = 1'b1;
        end else begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if ((cnt_in > 4'd13) || (cnt_in != exp_s)) begin
          evt_det_s = 1'b1;
          state_d   = SYNC;
        end else if (prev_load_q) begin
          evt_det_s  = 1'b1;
          evt_type_s = T_LOAD;
        end else if (prev_mode_q && (prev_cnt_q == 4'd13) && (cnt_in == 4'd0)) begin
          evt_det_s  = 1'b1;
          evt_type_s = T_WUP;
        end else if (!prev_mode_q && (prev_cnt_q == 4'd0) && (cnt_in == 4'd13)) begin
          evt_det_s  = 1'b1;
          evt_type_s = T_WDN;
        end else begin
          evt_det_s = 1'b0;
        end
      end
      default: state_d = SYNC;
    endcase
    evt_rec_s = {evt_type_s, 2'b00, cnt_in};
  end

  // FIFO bookkeeping, next-cycle head and statistics
  always_comb begin
    pop_s   = (count_q != '0) && evt_ready;
    push_s  = evt_det_s && ((count_q != DEPTH_C) || pop_s);
    drop_s  = evt_det_s && !push_s;
    rd_d    = pop_s  ? rd_q + AW'(1) : rd_q;
    wr_d    = push_s ? wr_q + AW'(1) : wr_q;
    count_d = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    // The pushed record becomes head only once everything ahead of it is gone.
    if (count_d == '0) begin
      evt_data_d = 8'h00;
    end else if ((count_q - (AW+1)'(pop_s)) == '0) begin
      evt_data_d = evt_rec_s;
    end else begin
      evt_data_d = mem_q[rd_d];
    end
    evt_valid_d = (count_d != '0);
    fifo_full_d = (count_d == DEPTH_C);
    ovf_d       = ovf_q | drop_s;
    if (evt_det_s && ((evt_type_s == T_WUP) || (evt_type_s == T_WDN))) begin
      wrap_d = sat_inc(wrap_q);
    end else begin
      wrap_d = wrap_q;
    end
    if (evt_det_s && (evt_type_s == T_ERR)) begin
      err_d = sat_inc(err_q);
    end else begin
      err_d = err_q;
    end
  end

  // State, sample history, FIFO pointers and registered outputs
  always_ff @(posedge clock) begin
    if (!rest) begin
      state_q     <= SYNC;
      prev_cnt_q  <= 4'd0;
      prev_mode_q <= 1'b0;
      prev_load_q <= 1'b0;
      prev_data_q <= 4'd0;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= 8'h00;
      fifo_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      wrap_q      <= 8'd0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_cnt_q  <= cnt_in;
      prev_mode_q <= mode;
      prev_load_q <= load;
      prev_data_q <= data_in;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      fifo_full_q <= fifo_full_d;
      ovf_q       <= ovf_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  // Event storage; contents are don't-care while the slot is not occupied
  always_ff @(posedge clock) begin
    if (rest && push_s) begin
      mem_q[wr_q] <= evt_rec_s;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign fifo_full = fifo_full_q;
  assign ovf       = ovf_q;
  assign wrap_cnt  = wrap_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_count_event_tracker.sv
// Bench for count_event_tracker: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_count_event_tracker;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       rest;
  logic [3:0] cnt_in;
  logic       mode;
  logic       load;
  logic [3:0] data_in;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       fifo_full;
  logic       ovf;
  logic [7:0] wrap_cnt;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit         m_trk;
  int         m_pc, m_pd;
  bit         m_pm, m_pl;
  logic [7:0] m_q[$];
  bit         m_ovf;
  int         m_wrap, m_err;

  count_event_tracker #(.FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rest      (rest),
    .cnt_in    (cnt_in),
    .mode      (mode),
    .load      (load),
    .data_in   (data_in),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .fifo_full (fifo_full),
    .ovf       (ovf),
    .wrap_cnt  (wrap_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clock = ~clock;

  task automatic model_update();
    int c, e;
    bit ev;
    bit dopop;
    logic [7:0] rec;
    if (!rest) begin
      m_trk = 0; m_pc = 0; m_pd = 0; m_pm = 0; m_pl = 0;
      m_q.delete(); m_ovf = 0; m_wrap = 0; m_err = 0;
      return;
    end
    c = int'(cnt_in);
    ev = 0;
    rec = 8'h00;
    if (!m_trk) begin
      if (c > 13) begin ev = 1; rec = {4'h0, cnt_in}; end
      else m_trk = 1;
    end else begin
      if (m_pl) e = m_pd;
      else if (m_pm) e = (m_pc + 1) % 14;
      else e = (m_pc + 13) % 14;
      if (c > 13 || c != e) begin ev = 1; rec = {4'h0, cnt_in}; m_trk = 0; end
      else if (m_pl) begin ev = 1; rec = {4'hC, cnt_in}; end
      else if (m_pm && m_pc == 13 && c == 0) begin ev = 1; rec = {4'h4, cnt_in}; end
      else if (!m_pm && m_pc == 0 && c == 13) begin ev = 1; rec = {4'h8, cnt_in}; end
    end
    if (ev && rec[7:6] == 2'b00) m_err = (m_err < 255) ? m_err + 1 : 255;
    if (ev && (rec[7:6] == 2'b01 || rec[7:6] == 2'b10)) m_wrap = (m_wrap < 255) ? m_wrap + 1 : 255;
    dopop = (m_q.size() > 0) && evt_ready;
    if (dopop) void'(m_q.pop_front());
    if (ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(rec);
      else m_ovf = 1;
    end
    m_pc = c; m_pd = int'(data_in); m_pm = mode; m_pl = load;
  endtask

  task automatic apply(input logic r, input logic [3:0] c, input logic m, input logic l,
                       input logic [3:0] d, input logic rdy);
    rest = r; cnt_in = c; mode = m; load = l; data_in = d; evt_ready = rdy;
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b1, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if ({evt_valid, evt_data, fifo_full, err_cnt} !== {1'b1, 8'h0F, 1'b0, 8'd3}) begin
      failures++;
      $display("FAIL reset_prefill got=%h exp=%h", {evt_valid, evt_data, fifo_full, err_cnt},
               {1'b1, 8'h0F, 1'b0, 8'd3});
    end
    apply(1'b0, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0);
    apply(1'b0, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if ({evt_valid, evt_data, fifo_full, ovf, wrap_cnt, err_cnt} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {evt_valid, evt_data, fifo_full, ovf, wrap_cnt, err_cnt});
    end
    apply(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if ({evt_valid, evt_data} !== 9'd0) begin
      failures++;
      $display("FAIL reset_after got=%h exp=0", {evt_valid, evt_data});
    end
  endtask

  task automatic test_up_wrap();
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    apply(1'b1, 4'd12, 1'b1, 1'b0, 4'd0, 1'b1);
    apply(1'b1, 4'd13, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL up_wrap_early got=%b exp=0", evt_valid);
    end
    apply(1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, evt_data, wrap_cnt} !== {1'b1, 8'h40, 8'd1}) begin
      failures++;
      $display("FAIL up_wrap_evt got=%h exp=%h", {evt_valid, evt_data, wrap_cnt}, {1'b1, 8'h40, 8'd1});
    end
    apply(1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, wrap_cnt, err_cnt} !== {1'b0, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL up_wrap_single got=%h exp=%h", {evt_valid, wrap_cnt, err_cnt}, {1'b0, 8'd1, 8'd0});
    end
  endtask

  task automatic test_down_wrap();
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    apply(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1);
    apply(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    apply(1'b1, 4'd13, 1'b0, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, evt_data, wrap_cnt} !== {1'b1, 8'h8D, 8'd1}) begin
      failures++;
      $display("FAIL down_wrap_evt got=%h exp=%h", {evt_valid, evt_data, wrap_cnt}, {1'b1, 8'h8D, 8'd1});
    end
  endtask

  task automatic test_load();
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    apply(1'b1, 4'd4, 1'b1, 1'b1, 4'd9, 1'b1);
    apply(1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, evt_data} !== {1'b1, 8'hC9}) begin
      failures++;
      $display("FAIL load_evt got=%h exp=%h", {evt_valid, evt_data}, {1'b1, 8'hC9});
    end
    apply(1'b1, 4'd10, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, err_cnt} !== {1'b0, 8'd0}) begin
      failures++;
      $display("FAIL load_follow_ok got=%h exp=%h", {evt_valid, err_cnt}, {1'b0, 8'd0});
    end
    apply(1'b1, 4'd12, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, evt_data, err_cnt} !== {1'b1, 8'h0C, 8'd1}) begin
      failures++;
      $display("FAIL load_follow_err got=%h exp=%h", {evt_valid, evt_data, err_cnt}, {1'b1, 8'h0C, 8'd1});
    end
  endtask

  task automatic test_error();
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    apply(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1);
    apply(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, evt_data, err_cnt} !== {1'b1, 8'h07, 8'd1}) begin
      failures++;
      $display("FAIL err_mismatch got=%h exp=%h", {evt_valid, evt_data, err_cnt}, {1'b1, 8'h07, 8'd1});
    end
    apply(1'b1, 4'd8, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, err_cnt} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL err_resync got=%h exp=%h", {evt_valid, err_cnt}, {1'b0, 8'd1});
    end
    apply(1'b1, 4'd15, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({evt_valid, evt_data, err_cnt} !== {1'b1, 8'h0F, 8'd2}) begin
      failures++;
      $display("FAIL err_range got=%h exp=%h", {evt_valid, evt_data, err_cnt}, {1'b1, 8'h0F, 8'd2});
    end
  endtask

  task automatic test_overflow();
    logic [3:0] seq [7];
    logic [7:0] heads [4];
    seq = '{4'd0, 4'd5, 4'd14, 4'd15, 4'd3, 4'd9, 4'd14};
    heads = '{8'h05, 8'h0E, 8'h0F, 8'h09};
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) apply(1'b1, seq[i], 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if ({fifo_full, ovf, evt_data} !== {1'b1, 1'b0, 8'h05}) begin
      failures++;
      $display("FAIL ovf_full got=%h exp=%h", {fifo_full, ovf, evt_data}, {1'b1, 1'b0, 8'h05});
    end
    apply(1'b1, seq[6], 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if ({fifo_full, ovf, evt_data, err_cnt} !== {1'b1, 1'b1, 8'h05, 8'd5}) begin
      failures++;
      $display("FAIL ovf_drop got=%h exp=%h", {fifo_full, ovf, evt_data, err_cnt}, {1'b1, 1'b1, 8'h05, 8'd5});
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 4'(i), 1'b1, 1'b0, 4'd0, 1'b1);
      checks++;
      if (i < 3) begin
        if ({evt_valid, evt_data, fifo_full, ovf} !== {1'b1, heads[i+1], 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL ovf_drain%0d got=%h exp=%h", i, {evt_valid, evt_data, fifo_full, ovf},
                   {1'b1, heads[i+1], 1'b0, 1'b1});
        end
      end else begin
        if ({evt_valid, evt_data, fifo_full, ovf} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL ovf_drain%0d got=%h exp=%h", i, {evt_valid, evt_data, fifo_full, ovf},
                   {1'b0, 8'h00, 1'b0, 1'b1});
        end
      end
    end
  endtask

  task automatic test_saturation();
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 300; i++) apply(1'b1, 4'd15, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL err_sat got=%0d exp=255", err_cnt);
    end
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 14 * 260; i++) apply(1'b1, 4'(i % 14), 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if ({wrap_cnt, err_cnt} !== {8'd255, 8'd0}) begin
      failures++;
      $display("FAIL wrap_sat got=%h exp=%h", {wrap_cnt, err_cnt}, {8'd255, 8'd0});
    end
  endtask

  task automatic test_random();
    int nc;
    logic [3:0] c, d;
    logic m, l, r, rdy;
    logic [27:0] exp_v;
    apply(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    nc = $urandom_range(0, 13);
    for (int i = 0; i < 800; i++) begin
      m   = 1'($urandom_range(0, 1));
      l   = ($urandom_range(0, 7) == 0);
      d   = 4'($urandom_range(0, 13));
      c   = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'(nc);
      rdy = ($urandom_range(0, 1) == 1);
      r   = ($urandom_range(0, 99) != 0);
      apply(r, c, m, l, d, rdy);
      if (l) nc = int'(d);
      else if (m) nc = (int'(c) + 1) % 14;
      else nc = (int'(c) + 13) % 14;
      exp_v = {m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 8'h00, m_q.size() == DEPTH,
               m_ovf, 8'(m_wrap), 8'(m_err)};
      checks++;
      if ({evt_valid, evt_data, fifo_full, ovf, wrap_cnt, err_cnt} !== exp_v) begin
        failures++;
        $display("FAIL random_cyc%0d got=%h exp=%h", i,
                 {evt_valid, evt_data, fifo_full, ovf, wrap_cnt, err_cnt}, exp_v);
      end
    end
  endtask

  initial begin
    rest = 1'b0; cnt_in = 4'd0; mode = 1'b0; load = 1'b0; data_in = 4'd0; evt_ready = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_error();
    test_overflow();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
